// File: rtl/reg_pkg.sv
// Shared defaults for the enabled, asynchronously reset data register.
package reg_pkg;

  localparam int unsigned REG_WIDTH = 8;
  localparam logic [REG_WIDTH-1:0] REG_RST_VAL = 8'h00;

endpackage

// File: rtl/dff_en_ar.sv
// Single-bit flop with load enable and asynchronous active-high reset.
module dff_en_ar #(
  parameter logic RstVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);

  logic q_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= RstVal;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/reg_8bit.sv
// WIDTH-bit register with load enable and asynchronous active-high reset, built bit by bit.
module reg_8bit
  import reg_pkg::*;
#(
  parameter int unsigned           WIDTH       = REG_WIDTH,
  parameter logic [WIDTH-1:0]      RESET_VALUE = WIDTH'(REG_RST_VAL)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic [WIDTH-1:0] data_In,
  output logic [WIDTH-1:0] data_Out
);

  logic [WIDTH-1:0] bits_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_en_ar #(
      .RstVal(RESET_VALUE[i])
    ) u_dff (
      .clk_i(clk),
      .rst_i(res),
      .en_i (en),
      .d_i  (data_In[i]),
      .q_o  (bits_q[i])
    );
  end

  assign data_Out = bits_q;

`ifndef SYNTHESIS
  // Set by any reset pulse since the last clean edge, so a mid-cycle reset
  // is not mistaken for an unwanted change while the enable is low.
  logic res_seen_q;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      res_seen_q <= 1'b1;
    end else begin
      res_seen_q <= 1'b0;
    end
  end

  a_reset_value: assert property (@(posedge clk) res |-> (data_Out == RESET_VALUE));

  a_hold_when_disabled: assert property (
    @(posedge clk) (!res && !en) |=> ($stable(data_Out) || res_seen_q)
  );
`endif

endmodule

// File: tb/tb_reg_8bit.sv
// Self-checking bench for reg_8bit: directed scenarios, then randomized traffic vs a model.
module tb_reg_8bit;

  localparam logic [7:0] RstVal = 8'h00;

  logic       clk;
  logic       res;
  logic       en;
  logic [7:0] data_In;
  logic [7:0] data_Out;

  int unsigned checks;
  int unsigned errors;
  logic [7:0]  exp_q;
  bit          run;

  reg_8bit #(
    .WIDTH      (8),
    .RESET_VALUE(RstVal)
  ) dut (
    .clk     (clk),
    .res     (res),
    .en      (en),
    .data_In (data_In),
    .data_Out(data_Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, req, $time);
    end
  endtask

  // Model: a register is "last value loaded by an enabled, non-reset edge,
  // or the reset value since the latest reset". Called 2 time units after a
  // rising edge; returns 2 units after the following rising edge.
  task automatic step(input logic r, input logic e, input logic [7:0] d);
    res     = r;
    en      = e;
    data_In = d;
    if (r) exp_q = RstVal;
    @(posedge clk);
    if (!r && e) exp_q = d;
    #2;
  endtask

  // Reset pulse landing between edges; the clear must be visible at once.
  task automatic mid_reset();
    #1 res = 1'b1;
    exp_q = RstVal;
    #1 check("mid_cycle_reset", data_Out, RstVal);
    res = 1'b0;
  endtask

  always @(negedge clk) begin
    if (run) check("cycle_compare", data_Out, exp_q);
  end

  initial begin
    checks  = 0;
    errors  = 0;
    run     = 1'b0;
    res     = 1'b1;
    en      = 1'b0;
    data_In = 8'h69;
    exp_q   = RstVal;

    #1 check("reset_before_clock", data_Out, 8'h00);
    @(posedge clk);
    #2;
    run = 1'b1;

    step(1'b0, 1'b0, 8'h69);
    step(1'b0, 1'b0, 8'h69);
    check("hold_after_reset", data_Out, 8'h00);

    step(1'b0, 1'b1, 8'h69);
    check("load_69", data_Out, 8'h69);

    step(1'b0, 1'b0, 8'hF8);
    step(1'b0, 1'b0, 8'hF8);
    step(1'b0, 1'b0, 8'h0F);
    check("hold_69_input_changes", data_Out, 8'h69);

    mid_reset();
    step(1'b0, 1'b0, 8'h69);
    check("stay_cleared_after_pulse", data_Out, 8'h00);
    step(1'b0, 1'b1, 8'hF8);
    check("load_F8_after_pulse", data_Out, 8'hF8);

    step(1'b1, 1'b1, 8'hFF);
    check("reset_beats_enable", data_Out, 8'h00);
    step(1'b1, 1'b1, 8'hFF);
    check("reset_beats_enable_2", data_Out, 8'h00);
    step(1'b0, 1'b1, 8'hFF);
    check("first_load_after_release", data_Out, 8'hFF);

    step(1'b0, 1'b1, 8'hA5);
    step(1'b0, 1'b1, 8'h5A);
    check("back_to_back_load", data_Out, 8'h5A);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(15) == 0), 1'($urandom), 8'($urandom));
      if ($urandom_range(19) == 0) mid_reset();
    end

    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
